// File: rtl/match_event_monitor_pkg.sv
// Shared definitions for the match event monitor and the layers around it:
// FSM encoding, default sizing and a small saturating-increment helper.
package match_event_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        TRACK = 2'b01,
        ALARM = 2'b10
    } state_e;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_WIN_LEN = 16;
    localparam int DEF_THRESH  = 3;

    // Window and hit counters are 8 bits wide and must never wrap.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/match_event_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module match_event_monitor_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/match_event_monitor.sv
// Consumes the detector's match pulse: counts matches, measures inter-match gaps
// and raises a sticky alarm when THRESH matches land inside one WIN_LEN window.
module match_event_monitor
    import match_event_monitor_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int WIN_LEN = DEF_WIN_LEN,
    parameter int THRESH  = DEF_THRESH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             match_in,
    input  logic             clr,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] gap_len,
    output logic             gap_valid,
    output logic             burst_alarm,
    output logic             win_active
);

    localparam logic [8:0] WIN_LAST = 9'(WIN_LEN - 1);
    localparam logic [8:0] THRESH_V = 9'(THRESH);

    state_e           state_q, state_d;
    logic [7:0]       win_ctr_q, win_ctr_d;
    logic [7:0]       hit_ctr_q, hit_ctr_d;
    logic             seen_q, seen_d;
    logic [CNT_W-1:0] gap_len_q, gap_len_d;
    logic             gap_valid_q, gap_valid_d;
    logic [CNT_W-1:0] gap_ctr;
    logic [8:0]       hit_next;

    match_event_monitor_sat_counter #(.W(CNT_W)) u_match_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .inc_i (match_in),
        .cnt_o (match_cnt)
    );

    // Restarted by every match so it always holds cycles since the last one.
    match_event_monitor_sat_counter #(.W(CNT_W)) u_gap_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr | match_in),
        .inc_i (1'b1),
        .cnt_o (gap_ctr)
    );

    assign hit_next = {1'b0, hit_ctr_q} + 9'd1;

    always_comb begin
        state_d   = state_q;
        win_ctr_d = win_ctr_q;
        hit_ctr_d = hit_ctr_q;
        if (clr) begin
            state_d   = IDLE;
            win_ctr_d = 8'd0;
            hit_ctr_d = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (match_in) begin
                        state_d   = TRACK;
                        win_ctr_d = 8'd1;
                        hit_ctr_d = 8'd1;
                    end
                end
                TRACK: begin
                    // Reaching the threshold outranks the window closing.
                    if (match_in && (hit_next == THRESH_V)) begin
                        state_d   = ALARM;
                        hit_ctr_d = hit_next[7:0];
                    end else if ({1'b0, win_ctr_q} == WIN_LAST) begin
                        if (match_in) begin
                            win_ctr_d = 8'd1;
                            hit_ctr_d = 8'd1;
                        end else begin
                            state_d   = IDLE;
                            win_ctr_d = 8'd0;
                            hit_ctr_d = 8'd0;
                        end
                    end else begin
                        win_ctr_d = sat_inc8(win_ctr_q);
                        if (match_in) begin
                            hit_ctr_d = sat_inc8(hit_ctr_q);
                        end
                    end
                end
                ALARM: begin
                    state_d = ALARM;
                end
                default: begin
                    state_d   = IDLE;
                    win_ctr_d = 8'd0;
                    hit_ctr_d = 8'd0;
                end
            endcase
        end
    end

    always_comb begin
        seen_d      = seen_q;
        gap_len_d   = gap_len_q;
        gap_valid_d = 1'b0;
        if (clr) begin
            seen_d    = 1'b0;
            gap_len_d = '0;
        end else if (match_in) begin
            seen_d = 1'b1;
            if (seen_q) begin
                gap_len_d   = (gap_ctr == {CNT_W{1'b1}}) ? gap_ctr : gap_ctr + CNT_W'(1);
                gap_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            win_ctr_q   <= 8'd0;
            hit_ctr_q   <= 8'd0;
            seen_q      <= 1'b0;
            gap_len_q   <= '0;
            gap_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_ctr_q   <= win_ctr_d;
            hit_ctr_q   <= hit_ctr_d;
            seen_q      <= seen_d;
            gap_len_q   <= gap_len_d;
            gap_valid_q <= gap_valid_d;
        end
    end

    assign gap_len     = gap_len_q;
    assign gap_valid   = gap_valid_q;
    assign burst_alarm = (state_q == ALARM);
    assign win_active  = (state_q == TRACK);

endmodule

// File: tb/tb_match_event_monitor.sv
// Directed scoreboard bench: stimulus queues expected gap events and level
// checkpoints; a monitor pops and compares them as the DUT produces them.
module tb_match_event_monitor;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          match_in = 1'b0;
    logic          clr = 1'b0;
    logic [CW-1:0] match_cnt;
    logic [CW-1:0] gap_len;
    logic          gap_valid;
    logic          burst_alarm;
    logic          win_active;

    always #5 clk = ~clk;

    match_event_monitor #(
        .CNT_W   (CW),
        .WIN_LEN (16),
        .THRESH  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .match_in    (match_in),
        .clr         (clr),
        .match_cnt   (match_cnt),
        .gap_len     (gap_len),
        .gap_valid   (gap_valid),
        .burst_alarm (burst_alarm),
        .win_active  (win_active)
    );

    typedef struct {
        int            cyc;
        logic [CW-1:0] len;
    } gap_exp_t;

    typedef struct {
        int            cyc;
        logic [CW-1:0] cnt;
        logic [CW-1:0] gap;
        logic          alarm;
        logic          win;
    } lvl_exp_t;

    gap_exp_t gap_q[$];
    lvl_exp_t lvl_q[$];
    int       pulse_q[$];
    int       clr_at = -1;
    int       rel = 0;
    bit       mon_en = 1'b0;
    int       n_tests = 0;
    int       n_fail = 0;
    string    test_name = "reset";

    function automatic void check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endfunction

    function automatic void flag(input string name, input int cyc);
        n_tests++;
        n_fail++;
        $display("FAIL %s at cycle %0d: got event expected none", name, cyc);
    endfunction

    function automatic logic [15:0] all_outs();
        return 16'({match_cnt, gap_len, gap_valid, burst_alarm, win_active});
    endfunction

    function automatic void push_gap(input int c, input int l);
        gap_exp_t e;
        e.cyc = c;
        e.len = CW'(l);
        gap_q.push_back(e);
    endfunction

    function automatic void push_lvl(input int c, input int cnt, input int gap, input int al, input int win);
        lvl_exp_t e;
        e.cyc   = c;
        e.cnt   = CW'(cnt);
        e.gap   = CW'(gap);
        e.alarm = al[0];
        e.win   = win[0];
        lvl_q.push_back(e);
    endfunction

    function automatic bit is_pulse(input int r);
        foreach (pulse_q[i]) if (pulse_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    // Outputs for "cycle rel+1" are sampled 1 ns after the edge that consumed rel.
    always @(posedge clk) begin : monitor
        int       cur;
        gap_exp_t ge;
        lvl_exp_t le;
        #1;
        if (mon_en) begin
            cur = rel + 1;
            while (gap_q.size() > 0 && gap_q[0].cyc < cur) begin
                ge = gap_q.pop_front();
                n_tests++;
                n_fail++;
                $display("FAIL %s missed gap_valid: got none expected at cycle %0d", test_name, ge.cyc);
            end
            if (gap_valid) begin
                if (gap_q.size() > 0 && gap_q[0].cyc == cur) begin
                    ge = gap_q.pop_front();
                    check($sformatf("%s gap_len@%0d", test_name, cur), 16'(gap_len), 16'(ge.len));
                end else begin
                    flag({test_name, " unexpected gap_valid"}, cur);
                end
            end
            while (lvl_q.size() > 0 && lvl_q[0].cyc == cur) begin
                le = lvl_q.pop_front();
                check($sformatf("%s cnt/gap/alarm/win@%0d", test_name, cur),
                      16'({match_cnt, gap_len, burst_alarm, win_active}),
                      16'({le.cnt, le.gap, le.alarm, le.win}));
            end
        end
    end

    task automatic run(input int len);
        for (int r = 0; r <= len; r++) begin
            @(negedge clk);
            rel      = r;
            mon_en   = 1'b1;
            match_in = is_pulse(r);
            clr      = (r == clr_at);
        end
        @(negedge clk);
        mon_en   = 1'b0;
        match_in = 1'b0;
        clr      = 1'b0;
        check({test_name, " pending gap events"}, 16'(gap_q.size()), 16'd0);
        check({test_name, " pending checkpoints"}, 16'(lvl_q.size()), 16'd0);
        gap_q.delete();
        lvl_q.delete();
        pulse_q.delete();
        clr_at = -1;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr      = 1'b1;
        match_in = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset all outputs", all_outs(), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;

        test_name = "idle";
        push_lvl(1, 0, 0, 0, 0);
        push_lvl(10, 0, 0, 0, 0);
        push_lvl(25, 0, 0, 0, 0);
        push_lvl(50, 0, 0, 0, 0);
        run(50);

        do_clr();
        test_name = "single";
        pulse_q = '{10};
        push_lvl(10, 0, 0, 0, 0);
        push_lvl(11, 1, 0, 0, 1);
        push_lvl(25, 1, 0, 0, 1);
        push_lvl(26, 1, 0, 0, 0);
        push_lvl(40, 1, 0, 0, 0);
        run(40);

        do_clr();
        test_name = "gap";
        pulse_q = '{10, 14, 24};
        push_gap(15, 4);
        push_gap(25, 10);
        push_lvl(11, 1, 0, 0, 1);
        push_lvl(15, 2, 4, 0, 1);
        push_lvl(24, 2, 4, 0, 1);
        push_lvl(25, 3, 10, 1, 0);
        push_lvl(45, 3, 10, 1, 0);
        run(45);

        do_clr();
        test_name = "restart";
        pulse_q = '{10, 25};
        push_gap(26, 15);
        push_lvl(25, 1, 0, 0, 1);
        push_lvl(26, 2, 15, 0, 1);
        push_lvl(40, 2, 15, 0, 1);
        push_lvl(41, 2, 15, 0, 0);
        run(45);

        do_clr();
        test_name = "cnt_sat";
        for (int k = 1; k <= 20; k++) pulse_q.push_back(5 * k);
        for (int k = 2; k <= 20; k++) push_gap(5 * k + 1, 5);
        push_lvl(6, 1, 0, 0, 1);
        push_lvl(16, 3, 5, 1, 0);
        push_lvl(71, 14, 5, 1, 0);
        push_lvl(76, 15, 5, 1, 0);
        push_lvl(101, 15, 5, 1, 0);
        push_lvl(110, 15, 5, 1, 0);
        run(110);

        do_clr();
        test_name = "gap_sat";
        pulse_q = '{10, 51};
        push_gap(52, 15);
        push_lvl(11, 1, 0, 0, 1);
        push_lvl(26, 1, 0, 0, 0);
        push_lvl(52, 2, 15, 0, 1);
        run(55);

        do_clr();
        test_name = "clr_prio";
        pulse_q = '{10, 11, 12, 20, 30};
        clr_at  = 20;
        push_gap(12, 1);
        push_gap(13, 1);
        push_lvl(13, 3, 1, 1, 0);
        push_lvl(20, 3, 1, 1, 0);
        push_lvl(21, 0, 0, 0, 0);
        push_lvl(25, 0, 0, 0, 0);
        push_lvl(31, 1, 0, 0, 1);
        push_lvl(33, 1, 0, 0, 1);
        run(32);

        test_name = "async_rst";
        @(posedge clk);
        #2;
        check("async_rst win_active before", 16'(win_active), 16'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst outputs mid-cycle", all_outs(), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("async_rst outputs after release", all_outs(), 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/match_event_monitor.md
Name: match_event_monitor

Overview:
- Downstream consumer of the serial sequence detector's one-cycle match pulse, z.
- Maintains a saturating total match count and measures the cycle gap between consecutive matches.
- Raises a sticky burst alarm when too many matches fall inside a sliding-start observation window.
- Sits between the detector and the status/register layer.

Parameters:
- CNT_W, 8, width of match_cnt, gap_len and internal gap counter.
- WIN_LEN, 16, window length in clock cycles, counted from the match that opens it; range 2..255.
- THRESH, 3, matches within one window that trigger the alarm; range 2..WIN_LEN.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- match_in  input  1  one-cycle match pulse from the detector; sampled every clk.
- clr  input  1  synchronous clear of counters, alarm and FSM.
- match_cnt  output  CNT_W  total matches since reset/clr; saturates at all-ones.
- gap_len  output  CNT_W  cycles between the last two matches; saturates at all-ones.
- gap_valid  output  1  one-cycle pulse when gap_len updates.
- burst_alarm  output  1  sticky alarm level.
- win_active  output  1  high while a window is open (state TRACK).

Behaviour:
Reset (rst_n low, asynchronous):
- All outputs 0; state IDLE; win_ctr=0, hit_ctr=0, gap_ctr=0, seen=0.

clr (synchronous):
- Same effect as reset on the next edge.
- Has priority over match_in in the same cycle; that match is discarded.

Registered outputs:
- All outputs are registered.
- A match sampled at edge N is reflected in outputs after edge N, so visible in cycle N+1.

match_cnt:
- Increments by 1 per match; holds at 2^CNT_W-1.

Gap measurement:
- gap_ctr counts cycles since the previous match, saturating at all-ones.
- On a match with seen=1: gap_len <= gap_ctr+1 (saturating); gap_valid pulses one cycle; gap_ctr <= 0.
- Matches on consecutive cycles give gap_len=1.
- On the first match after reset/clr: seen <= 1, gap_ctr <= 0, no gap_valid.

FSM states IDLE, TRACK, ALARM:
- IDLE:
  - match -> TRACK; win_ctr <= 1; hit_ctr <= 1.
- TRACK:
  - win_ctr increments every cycle.
  - A match increments hit_ctr.
  - If hit_ctr+1 == THRESH on a match -> ALARM; burst_alarm <= 1.
  - If win_ctr == WIN_LEN-1 and no match in that cycle -> IDLE; hit_ctr <= 0.
  - If win_ctr == WIN_LEN-1 with a match that does not reach THRESH -> new window opens: stay TRACK, win_ctr <= 1, hit_ctr <= 1.
  - Threshold check takes priority over expiry in the same cycle.
- ALARM:
  - burst_alarm held at 1 until clr or reset.
  - Window counters frozen.
  - match_cnt and gap logic keep running.
- win_active = (state==TRACK), registered with state.

Widths:
- win_ctr and hit_ctr are 8 bits.
- Comparisons against WIN_LEN/THRESH are unsigned.
- No wrap-around anywhere; every counter saturates.

Reset mid-window:
- rst_n low in any state returns to IDLE immediately (asynchronous), with outputs at 0.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, TRACK=2'b01, ALARM=2'b10, 2'b11 unused -> IDLE.
  - Default CNT_W/WIN_LEN/THRESH constants, for use by the detector top and register layer.
- One natural sub-module, sat_counter: parameterised width, inc/clr, saturating. Instantiated for match_cnt and gap_ctr.
- FSM and window logic stay in the top module.

Test Plan:
1. Reset then idle: rst_n low 3 cycles then high, match_in=0 for 50 cycles -> all outputs 0, win_active=0 throughout.
2. Single match then expiry: one pulse at cycle 10 -> match_cnt=1 from cycle 11; win_active high cycles 11..25, low from 26; no gap_valid; burst_alarm=0.
3. Gap measurement: pulses at cycles 10, 14, 24 ->
   - gap_valid at cycles 15 (gap_len=4) and 25 (gap_len=10);
   - match_cnt ends at 3;
   - burst_alarm rises at cycle 25 (3 hits within 16 cycles) and stays high.
4. Window restart on expiry edge: pulses at cycle 10 and cycle 25 (win_ctr=15), THRESH=3 -> win_active stays high; window restarts with hit_ctr=1; no alarm.
5. Saturation: CNT_W=4, 20 pulses spaced 5 cycles apart -> match_cnt holds 15 after the 15th. Gap: 40 idle cycles between two pulses -> gap_len=15.
6. Priority and async reset:
   - clr coincident with a match while in ALARM -> next cycle all outputs 0, state IDLE, match_cnt=0.
   - rst_n pulsed low mid-cycle while in TRACK -> outputs clear immediately, without waiting for a clock edge.
